// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Brief    : Shared types and defaults for the serial-adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  // Default configuration of the scheduler
  localparam int c_N_REQ_DEFAULT   = 4;
  localparam int c_TIMEOUT_DEFAULT = 8;
  localparam int c_DRAIN_DEFAULT   = 6;

  // Operand and result widths of the shared 2-bit serial adder
  localparam int c_OPND_W = 2;
  localparam int c_RES_W  = 3;

  // Result reported when the adder never answers
  localparam logic [c_RES_W-1:0] c_RES_TIMEOUT = 3'b111;

  // Scheduler state encoding
  typedef enum logic [2:0] {
    ST_DRAIN    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SEND_MSB = 3'd2,
    ST_SEND_LSB = 3'd3,
    ST_WAIT     = 3'd4,
    ST_CAP1     = 3'd5,
    ST_CAP0     = 3'd6,
    ST_RESP     = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. The search starts one past
//            the last winner and wraps; returns a one-hot grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] w_cand;

  // Walk the requesters in rotated order and keep the first one found
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = PTR_W'((int'(last_i) + i) % N_REQ);
      if (!valid_o && req_i[w_cand]) begin
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sched
// Brief    : Round-robin scheduler that shares one 2-bit serial adder among
//            N_REQ requesters. Operands are sent MSB first, the 3-bit sum is
//            collected serially and returned with a one-cycle done pulse.
//            The adder has no reset, so a drain period follows reset and
//            adder timeouts before new work is issued.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int N_REQ   = c_N_REQ_DEFAULT,
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
  parameter int DRAIN   = c_DRAIN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [2*N_REQ-1:0]    a_i,
  input  logic [2*N_REQ-1:0]    b_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [c_RES_W-1:0]    res_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  add_en_o,
  output logic                  add_ina_o,
  output logic                  add_inb_o,
  input  logic                  add_en_i,
  input  logic                  add_out_i
);

  localparam int c_PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST   = c_CNT_W'(DRAIN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_LAST_RST     = c_PTR_W'(N_REQ - 1);

  // Control state
  state_e                 state_q, state_d;
  logic [c_CNT_W-1:0]     cnt_q, cnt_d;
  logic [c_PTR_W-1:0]     last_q, last_d;
  logic [N_REQ-1:0]       win_q, win_d;
  logic [c_OPND_W-1:0]    a_q, a_d;
  logic [c_OPND_W-1:0]    b_q, b_d;
  // Upper two sum bits; the LSB goes straight to the output register
  logic [1:0]             res_q, res_d;

  // Registered outputs
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [N_REQ-1:0]       done_q, done_d;
  logic [c_RES_W-1:0]     res_out_q, res_out_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   add_en_q, add_en_d;
  logic                   ina_q, ina_d;
  logic                   inb_q, inb_d;

  // Arbiter results
  logic [N_REQ-1:0]       w_gnt;
  logic [c_PTR_W-1:0]     w_win_idx;
  logic                   w_valid;
  logic [c_OPND_W-1:0]    w_a_sel;
  logic [c_OPND_W-1:0]    w_b_sel;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (c_PTR_W)
  ) u_arb (
    .req_i   (req_i),
    .last_i  (last_q),
    .gnt_o   (w_gnt),
    .idx_o   (w_win_idx),
    .valid_o (w_valid)
  );

  // Pick the winning requester's operand pair out of the packed buses
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_a_sel = a_i[2*k +: 2];
        w_b_sel = b_i[2*k +: 2];
      end
    end
  end

  // Next-state and next-output logic; outputs reflect the state being entered
  // for gnt/done, and the state being left for the adder drive
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    gnt_d     = '0;
    done_d    = '0;
    res_out_d = '0;
    err_d     = 1'b0;
    add_en_d  = 1'b0;
    ina_d     = 1'b0;
    inb_d     = 1'b0;

    case (state_q)
      ST_DRAIN: begin
        if (cnt_q == c_DRAIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (w_valid) begin
          state_d = ST_SEND_MSB;
          gnt_d   = w_gnt;
          win_d   = w_gnt;
          last_d  = w_win_idx;
          a_d     = w_a_sel;
          b_d     = w_b_sel;
          res_d   = '0;
        end
      end
      ST_SEND_MSB: begin
        add_en_d = 1'b1;
        ina_d    = a_q[1];
        inb_d    = b_q[1];
        state_d  = ST_SEND_LSB;
      end
      ST_SEND_LSB: begin
        ina_d   = a_q[0];
        inb_d   = b_q[0];
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_en_i) begin
          res_d[1] = add_out_i;
          state_d  = ST_CAP1;
        end else if (cnt_q == c_TIMEOUT_LAST) begin
          state_d   = ST_RESP;
          done_d    = win_q;
          res_out_d = c_RES_TIMEOUT;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      ST_CAP1: begin
        res_d[0] = add_out_i;
        state_d  = ST_CAP0;
      end
      ST_CAP0: begin
        state_d   = ST_RESP;
        done_d    = win_q;
        res_out_d = {res_q, add_out_i};
      end
      ST_RESP: begin
        // A timed-out adder may still be mid-sequence, so let it settle
        cnt_d   = '0;
        state_d = err_q ? ST_DRAIN : ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset into the drain period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DRAIN;
      cnt_q     <= '0;
      last_q    <= c_LAST_RST;
      win_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      res_out_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
      add_en_q  <= 1'b0;
      ina_q     <= 1'b0;
      inb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      res_out_q <= res_out_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      add_en_q  <= add_en_d;
      ina_q     <= ina_d;
      inb_q     <= inb_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign res_o     = res_out_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign add_en_o  = add_en_q;
  assign add_ina_o = ina_q;
  assign add_inb_o = inb_q;

endmodule
`default_nettype wire

// File: doc/serial_add_sched.md
SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 2-bit serial adder.
REQ-002 Parameter TIMEOUT, default 8, maximum WAIT cycles for adder en_o.
REQ-003 Parameter DRAIN, default 6, post-reset idle cycles before first grant.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  N_REQ  per-requester request level.
REQ-007 a_i, b_i  in  2*N_REQ each  packed 2-bit operands; requester k uses bits [2k+1:2k].
REQ-008 gnt_o  out  N_REQ  one-hot, one-cycle grant pulse; operands latched that cycle.
REQ-009 done_o  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-010 res_o  out  3  sum, valid only while any done_o bit is high, else 0.
REQ-011 err_o  out  1  one-cycle pulse with done_o on adder timeout.
REQ-012 busy_o  out  1  high in every state except IDLE (and high during DRAIN).
REQ-013 add_en_o, add_ina_o, add_inb_o  out  1 each  drive adder en_i, ina, inb.
REQ-014 add_en_i, add_out_i  in  1 each  adder en_o and out_c.

Function
REQ-015 States: DRAIN, IDLE, SEND_MSB, SEND_LSB, WAIT, CAP1, CAP0, RESP; all outputs registered.
REQ-016 IDLE: if any req_i set, round-robin select winner, pulse gnt_o[winner], latch a/b, go SEND_MSB; else stay.
REQ-017 Round-robin: search starts at (last winner + 1) mod N_REQ; after reset last winner = N_REQ-1, so requester 0 has first priority.
REQ-018 SEND_MSB: add_en_o=1, add_ina_o=a[1], add_inb_o=b[1]; next SEND_LSB.
REQ-019 SEND_LSB: add_en_o=0, add_ina_o=a[0], add_inb_o=b[0]; next WAIT; add_en_o never high outside SEND_MSB.
REQ-020 WAIT: when add_en_i=1 capture res[2]=add_out_i, go CAP1; nominal WAIT length 1 cycle.
REQ-021 CAP1: res[1]=add_out_i; CAP0: res[0]=add_out_i; then RESP.
REQ-022 RESP: done_o[winner]=1, res_o=res for exactly one cycle (also the adder's return-to-idle cycle); next IDLE.
REQ-023 Latency: done_o asserts exactly 6 cycles after the gnt_o cycle when the adder responds nominally.
REQ-024 Timeout: WAIT counter reaching TIMEOUT without add_en_i -> RESP with res_o=3'b111 and err_o=1, then DRAIN.
REQ-025 Sum is unsigned 2+2 -> 3 bits, no wrap (max 3'b110).
REQ-026 req_i deasserting after grant does not cancel the operation; req_i still high after done_o is a new request.
REQ-027 req_i changes outside IDLE are ignored; no grant while busy.
REQ-028 add_ina_o/add_inb_o are 0 outside SEND states.

Reset
REQ-029 rst asserted at any time (including mid-operation): state DRAIN, gnt_o=0, done_o=0, res_o=0, err_o=0, add_* outputs=0, busy_o=1, counters 0, last winner N_REQ-1.
REQ-030 DRAIN holds DRAIN cycles after rst release (the adder has no reset), then IDLE; no in-flight operation resumes.

Structure
REQ-031 Shared package serial_add_pkg holds state encoding, N_REQ/TIMEOUT/DRAIN defaults, result width 3.
REQ-032 One sub-module rr_arbiter (N_REQ-wide request, last-winner pointer in, one-hot grant out, combinational).

Verification
REQ-033 Single: after drain, req_i=0001, a=2'b11, b=2'b10 -> gnt_o=0001, add_en_o pulse next cycle, done_o=0001 six cycles after grant, res_o=3'b101.
REQ-034 Fairness: req_i=1111 held -> grants 0001,0010,0100,1000,0001; each done before next grant.
REQ-035 Boundary: a=b=2'b00 -> res_o=000; a=b=2'b11 -> res_o=110.
REQ-036 Timeout: adder model suppresses en_o -> err_o=1, res_o=111 after WAIT of 8 cycles, then 6 drain cycles before next grant.
REQ-037 Mid-op reset: rst in CAP1 -> all outputs 0 asynchronously, no done_o, first grant no earlier than 7 cycles after release.
REQ-038 Protocol checker: add_en_o high at most one cycle per grant; never high while adder model is busy.
